// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler for a shared packet bus: pops one driver FIFO head per grant
// and delivers it to the destination driver (unicast or broadcast), counting deliveries and drops.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for any pndng bit; latches the round-robin winner
//   S_POP  | dequeue strobe to the granted driver, capture its head data
//   S_PUSH | enqueue strobe(s) to the destination(s), or count a drop
module bus_rr_scheduler #(
    parameter int         DRVRS     = 4,
    parameter int         PCKG_SZ   = 16,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DRVRS-1:0]           pndng,
    input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]           pop,
    output logic [DRVRS-1:0]           push,
    output logic [PCKG_SZ-1:0]         D_push,
    output logic                       busy,
    output logic [3:0]                 grant_id,
    output logic [15:0]                pkt_cnt,
    output logic [7:0]                 drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    localparam logic [7:0] DRVRS_B = 8'(DRVRS);
    localparam logic [3:0] LAST_RST = 4'(DRVRS - 1);

    state_t               state_q, state_d;
    logic [3:0]           grant_q, grant_d;
    logic [3:0]           last_q, last_d;
    logic [PCKG_SZ-1:0]   data_q, data_d;
    logic [15:0]          pkt_q, pkt_d;
    logic [7:0]           drop_q, drop_d;

    logic [3:0]           winner;
    logic                 found;
    logic [4:0]           cand;
    logic                 pndng_gnt;
    logic [PCKG_SZ-1:0]   head_data;
    logic [7:0]           dest;

    assign dest = data_q[PCKG_SZ-1 -: 8];

    // First pending driver after last_grant, ascending with wrap.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= DRVRS; i++) begin
            cand = {1'b0, last_q} + 5'(i);
            if (cand >= 5'(DRVRS))
                cand = cand - 5'(DRVRS);
            for (int j = 0; j < DRVRS; j++) begin
                if (!found && cand == 5'(j) && pndng[j]) begin
                    found  = 1'b1;
                    winner = 4'(j);
                end
            end
        end
    end

    always_comb begin
        pndng_gnt = 1'b0;
        head_data = '0;
        for (int j = 0; j < DRVRS; j++) begin
            if (grant_q == 4'(j)) begin
                pndng_gnt = pndng[j];
                head_data = D_pop[j*PCKG_SZ +: PCKG_SZ];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        pkt_d   = pkt_q;
        drop_d  = drop_q;
        pop     = '0;
        push    = '0;
        case (state_q)
            S_IDLE: begin
                if (|pndng) begin
                    grant_d = winner;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                for (int j = 0; j < DRVRS; j++)
                    if (grant_q == 4'(j))
                        pop[j] = pndng[j];
                if (pndng_gnt) begin
                    data_d  = head_data;
                    last_d  = grant_q;
                    state_d = S_PUSH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PUSH: begin
                state_d = S_IDLE;
                if (dest == BROADCAST) begin
                    for (int j = 0; j < DRVRS; j++)
                        push[j] = (grant_q != 4'(j));
                    pkt_d = pkt_q + 16'd1;
                end else if (dest < DRVRS_B && dest != {4'b0000, grant_q}) begin
                    for (int j = 0; j < DRVRS; j++)
                        push[j] = (dest == 8'(j));
                    pkt_d = pkt_q + 16'd1;
                end else if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            data_q  <= '0;
            pkt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
        end
    end

    // The captured packet doubles as the bus value, so it holds between transfers.
    assign D_push   = data_q;
    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_q;
    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler: unicast, fairness, broadcast, drops,
// abort, asynchronous reset and drop-counter saturation.
module tb_bus_rr_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] d_pop;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [15:0] d_push;
    logic        busy;
    logic [3:0]  grant_id;
    logic [15:0] pkt_cnt;
    logic [7:0]  drop_cnt;

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] pkt_before;
    logic [7:0]  drop_before;

    bus_rr_scheduler #(.DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push),
        .busy     (busy),
        .grant_id (grant_id),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One full transfer starting from IDLE; checks the POP and PUSH cycles.
    task automatic xfer(input logic [3:0] pn, input logic [3:0] exp_gnt,
                        input logic [3:0] exp_push, input logic [15:0] exp_data);
        @(negedge clk);
        pndng = pn;
        @(negedge clk);
        chk("pop", {28'd0, pop}, 32'd1 << exp_gnt);
        chk("grant", {28'd0, grant_id}, {28'd0, exp_gnt});
        chk("busy_pop", {31'd0, busy}, 32'd1);
        chk("push_in_pop", {28'd0, push}, 32'd0);
        @(negedge clk);
        chk("push", {28'd0, push}, {28'd0, exp_push});
        chk("d_push", {16'd0, d_push}, {16'd0, exp_data});
        chk("pop_in_push", {28'd0, pop}, 32'd0);
        pndng = 4'b0000;
        @(negedge clk);
        chk("push_idle", {28'd0, push}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("d_push_hold", {16'd0, d_push}, {16'd0, exp_data});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        pndng = 4'b0000;
        d_pop = '0;
        #1;
        chk("rst_pop", {28'd0, pop}, 32'd0);
        chk("rst_push", {28'd0, push}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant", {28'd0, grant_id}, 32'd0);
        chk("rst_dpush", {16'd0, d_push}, 32'd0);
        chk("rst_pkt", {16'd0, pkt_cnt}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single unicast driver 0 -> driver 2
        d_pop[0*16 +: 16] = 16'h02AB;
        xfer(4'b0001, 4'd0, 4'b0100, 16'h02AB);
        chk("uni_pkt", {16'd0, pkt_cnt}, 32'd1);

        // Fairness with all drivers pending
        do_reset();
        d_pop = {16'h0000, 16'h0300, 16'h0200, 16'h0100};
        @(negedge clk);
        pndng = 4'b1111;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c % 3 == 1) begin
                chk("fair_pop", {28'd0, pop}, 32'd1 << ((c - 1) / 3));
                chk("fair_gnt", {28'd0, grant_id}, 32'((c - 1) / 3));
            end else begin
                chk("fair_nopop", {28'd0, pop}, 32'd0);
            end
        end
        pndng = 4'b0000;
        chk("fair_pkt", {16'd0, pkt_cnt}, 32'd4);

        // Broadcast from driver 2
        pkt_before = pkt_cnt;
        d_pop[2*16 +: 16] = 16'hFF55;
        xfer(4'b0100, 4'd2, 4'b1011, 16'hFF55);
        chk("bc_pkt", {16'd0, pkt_cnt}, {16'd0, pkt_before + 16'd1});

        // Drops: out-of-range destination, then destination == source
        pkt_before = pkt_cnt;
        d_pop[1*16 +: 16] = 16'h0711;
        xfer(4'b0010, 4'd1, 4'b0000, 16'h0711);
        d_pop[1*16 +: 16] = 16'h0122;
        xfer(4'b0010, 4'd1, 4'b0000, 16'h0122);
        chk("drop_cnt2", {24'd0, drop_cnt}, 32'd2);
        chk("drop_pkt", {16'd0, pkt_cnt}, {16'd0, pkt_before});

        // Abort: pndng[3] falls during POP
        pkt_before  = pkt_cnt;
        drop_before = drop_cnt;
        d_pop[3*16 +: 16] = 16'h0033;
        d_pop[0*16 +: 16] = 16'h0000;
        @(negedge clk);
        pndng = 4'b1000;
        @(posedge clk);
        #1 pndng = 4'b0000;
        @(negedge clk);
        chk("abort_gnt", {28'd0, grant_id}, 32'd3);
        chk("abort_pop", {28'd0, pop}, 32'd0);
        @(negedge clk);
        chk("abort_push", {28'd0, push}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_pkt", {16'd0, pkt_cnt}, {16'd0, pkt_before});
        chk("abort_drop", {24'd0, drop_cnt}, {24'd0, drop_before});
        // last_grant still 1, so driver 3 beats driver 0
        xfer(4'b1001, 4'd3, 4'b0001, 16'h0033);

        // Asynchronous reset in the middle of PUSH
        d_pop[0*16 +: 16] = 16'h0155;
        @(negedge clk);
        pndng = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_push", {28'd0, push}, 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("arst_push", {28'd0, push}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_pkt", {16'd0, pkt_cnt}, 32'd0);
        chk("arst_drop", {24'd0, drop_cnt}, 32'd0);
        chk("arst_dpush", {16'd0, d_push}, 32'd0);
        chk("arst_grant", {28'd0, grant_id}, 32'd0);
        @(negedge clk);
        pndng = 4'b0000;
        reset = 1'b1;

        // Drop counter saturation: driver 0 repeatedly sends to itself
        d_pop[0*16 +: 16] = 16'h0000;
        @(negedge clk);
        pndng = 4'b0001;
        repeat (765) @(posedge clk);
        @(negedge clk);
        chk("sat_255", {24'd0, drop_cnt}, 32'd255);
        repeat (3) @(posedge clk);
        @(negedge clk);
        pndng = 4'b0000;
        chk("sat_hold", {24'd0, drop_cnt}, 32'd255);
        chk("sat_pkt", {16'd0, pkt_cnt}, 32'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_rr_scheduler.md
BUS_RR_SCHEDULER -- requirements
Module: bus_rr_scheduler

Interface
REQ-001 The block SHALL have parameter DRVRS, default 4, meaning the number of bus drivers (2..16).
REQ-002 The block SHALL have parameter PCKG_SZ, default 16, meaning the packet width in bits; the top 8 bits hold the destination ID.
REQ-003 The block SHALL have parameter BROADCAST, default 8'hFF, meaning the destination ID that delivers a packet to all drivers except the source.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset; low clears all state immediately, regardless of clk.
REQ-006 The block SHALL have port pndng, input, DRVRS bits: bit i high means driver i's FIFO holds a packet at its head.
REQ-007 The block SHALL have port D_pop, input, DRVRS*PCKG_SZ bits: slice i is driver i's FIFO head data, valid while pndng[i] is high.
REQ-008 The block SHALL have port pop, output, DRVRS bits: one-cycle dequeue strobe to driver i.
REQ-009 The block SHALL have port push, output, DRVRS bits: one-cycle enqueue strobe to driver i.
REQ-010 The block SHALL have port D_push, output, PCKG_SZ bits: packet broadcast on the shared bus.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port grant_id, output, 4 bits: index of the currently or last granted driver.
REQ-013 The block SHALL have port pkt_cnt, output, 16 bits: number of delivered packets, wrapping modulo 2^16.
REQ-014 The block SHALL have port drop_cnt, output, 8 bits: number of dropped packets, saturating at 255.

Function
REQ-015 The block SHALL implement the FSM states IDLE, POP and PUSH.
REQ-016 In IDLE with pndng != 0, the block SHALL latch the round-robin winner into grant_id and enter POP at the next edge; with pndng == 0 it SHALL stay in IDLE.
REQ-017 Round robin: the search SHALL start at (last_grant+1) mod DRVRS and ascend with wrap; the first set pndng bit wins.
REQ-018 last_grant SHALL update only when a pop is issued.
REQ-019 In POP, pop[grant_id] SHALL equal pndng[grant_id], and all other pop bits SHALL be 0.
REQ-020 In POP, the block SHALL capture D_pop[grant_id] into a data register at the closing edge and go to PUSH.
REQ-021 If pndng[grant_id] is low in POP, the block SHALL issue no pop, abort to IDLE, leave last_grant unchanged and push nothing.
REQ-022 In PUSH with dest = data[PCKG_SZ-1:PCKG_SZ-8] < DRVRS and dest != grant_id, push[dest] SHALL be 1 for one cycle, D_push = data, and pkt_cnt SHALL increment.
REQ-023 In PUSH with dest == BROADCAST, push SHALL be all ones except bit grant_id, and pkt_cnt SHALL increment by 1.
REQ-024 In PUSH with dest >= DRVRS (non-broadcast) or dest == grant_id, push SHALL stay 0 and drop_cnt SHALL increment, saturating at 255.
REQ-025 The block SHALL always leave PUSH to IDLE, so each packet costs exactly 3 cycles and a new grant is at most every 3 cycles.
REQ-026 Latency SHALL be: pndng sampled at edge k → pop high in cycle k..k+1 → push high in cycle k+1..k+2.
REQ-027 pop and push SHALL be Moore-decoded from state, except for the pndng gate in REQ-019; they SHALL never be high in the same cycle.
REQ-028 D_push SHALL hold its last value outside PUSH.
REQ-029 pndng changes during PUSH SHALL NOT affect the current transfer.

Reset
REQ-030 While reset is low, the block SHALL force: state = IDLE, pop = 0, push = 0, D_push = 0, busy = 0, grant_id = 0, last_grant = DRVRS-1 (driver 0 wins first), pkt_cnt = 0, drop_cnt = 0.
REQ-031 Reset asserted mid-POP or mid-PUSH SHALL abort the transfer with no further strobes; the packet's fate (popped or lost) is not retried.
REQ-032 After reset is released, the first grant SHALL occur at the first rising edge where pndng != 0.

Verification
REQ-033 Single unicast: pndng=4'b0001, D_pop[0]=16'h02AB → pop[0] one cycle, then push=4'b0100 with D_push=16'h02AB; pkt_cnt=1.
REQ-034 Fairness: pndng held at 4'b1111 for 12 cycles → grant_id sequence 0,1,2,3 with one pop every 3 cycles.
REQ-035 Broadcast: driver 2 sends 16'hFF55 → push=4'b1011, D_push=16'hFF55; pkt_cnt increments by 1.
REQ-036 Drops: driver 1 sends 16'h0711 (dest 7), then 16'h0122 (dest == self) → push stays 0; drop_cnt=2; pkt_cnt unchanged. Separately, force drop_cnt to 255 plus one more drop → drop_cnt stays 255.
REQ-037 Abort and reset: pndng[3] drops during POP → no pop, no push, and the next grant is still 3. Reset asserted in PUSH asynchronously (no clk edge) → push = 0 and all counters = 0 immediately.
